cop0_unit: RTL and testbench
============================

// Module: cop0_unit
// PURPOSE
//  MIPS coprocessor-0 for the single-cycle core. Holds the system registers
//  (Status, Cause, EPC, Count, Compare, BadVAddr, PRId).
//  Services MFC0/MTC0, SYSCALL, BREAK and ERET, latches hardware interrupts and
//  the timer interrupt, and supplies the redirect address (exception vector or EPC) to the PC unit.
// PARAMETERS
//  EXC_VECTOR  32'h0000_0180  handler address driven on out_data when an exception or interrupt is taken
//  PRID_VALUE  32'h0001_8000  read-only PRId contents
// PORTS
//  clk       in   1   single clock; all state updates on rising edge
//  rst       in   1   asynchronous, active-high reset
//  reg_num   in   5   CP0 register number (instr rd field)
//  reg_sel   in   3   CP0 select (instr[2:0]); only sel 0 exists
//  in_data   in  32   MTC0 write data ([rt])
//  next_pc   in  32   PC+4 of the current instruction
//  reg_wr    in   1   MTC0 strobe
//  reg_rd    in   1   MFC0 strobe
//  cop_op    in   4   COP_NOP=0, COP_SYSCALL=1, COP_BREAK=2, COP_ERET=3; all other codes act as NOP
//  code      in  20   SYSCALL/BREAK code field; stored nowhere, ignored
//  hard_int  in   6   level-sensitive external interrupt lines
//  out_data  out 32   combinational: redirect address or MFC0 data
//  exc_req   out  1   combinational: enabled interrupt pending, PC must take out_data
// BEHAVIOUR
//  Registers (sel 0):
//   BadVAddr=8 (read-only, 0); Count=9; Compare=11; Status=12; Cause=13; EPC=14; PRId=15 (PRID_VALUE).
//  Status fields: IE=bit0, EXL=bit1, IM=bits[15:8]; all other bits read 0.
//  Cause fields: ExcCode=[6:2], IP=[15:8], BD=bit31 (always 0).
//  Reset: every register 0 except PRId. out_data=0 unless a cop_op/reg_rd is active. exc_req=0.
//  Each clock:
//   - Count++ (wraps 0xFFFF_FFFF->0).
//   - Cause.IP[7:2] <= hard_int | {timer,5'b0}.
//   - timer is a sticky flag: set when Count==Compare (Compare!=0); cleared by an MTC0 to Compare.
//  MTC0 (reg_wr, reg_sel==0): write the target on the edge.
//   - Status: only IE/EXL/IM are writable.
//   - Cause: only IP[1:0] is writable.
//   - Count/Compare/EPC: full width.
//   - Any other number or sel: ignored.
//   - Write to Count overrides the increment in that cycle.
//  MFC0 (reg_rd): out_data = selected register. Unmapped number or sel!=0 -> 0.
//  pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM); exc_req = pending & (cop_op==COP_NOP).
//  SYSCALL/BREAK:
//   - out_data=EXC_VECTOR combinationally.
//   - On the edge: EPC<=next_pc-4, ExcCode<=8/9, EXL<=1.
//   - Taken regardless of IE/EXL.
//  ERET: out_data=EPC combinationally; EXL<=0 on the edge.
//  Interrupt (exc_req=1):
//   - out_data=EXC_VECTOR.
//   - On the edge: EPC<=next_pc (current instruction completes), ExcCode<=0, EXL<=1.
//  out_data priority: SYSCALL/BREAK > ERET > exc_req > reg_rd > 0.
//  Simultaneous events:
//   - cop_op beats an interrupt; the interrupt is re-evaluated next cycle.
//   - MTC0 in the same cycle as exception entry: the exception's EPC/EXL/ExcCode updates win.
//  Reset mid-operation clears all state immediately (async); pending exceptions are lost.
// STRUCTURE
//  Shared package/defines (common.v):
//   - COP_* op codes, CP0 register numbers, ExcCode values (INT=0, SYS=8, BP=9), Status/Cause bit positions.
//  One sub-module: cop0_timer (Count, Compare, sticky timer flag, write-override logic).
//  The rest stays flat: register file, mux, entry/exit logic.
// TESTING
//  1 Reset: rst=1 then 0; MFC0 12,13,14,9 -> 0; MFC0 15 -> 32'h0001_8000; exc_req=0.
//  2 SYSCALL, next_pc=32'h0000_3008:
//    - out_data=32'h0000_0180 in that cycle.
//    - After the edge: EPC=32'h0000_3004, Cause[6:2]=8, Status.EXL=1.
//    - Then ERET -> out_data=32'h0000_3004; EXL=0 after the edge.
//  3 MTC0 Status=32'h0000_0401, hard_int=6'b000001:
//    - Next cycle: Cause.IP2=1 and exc_req=1 with out_data=32'h0000_0180.
//    - After the edge: EPC=next_pc, ExcCode=0, EXL=1, exc_req=0.
//  4 MTC0 Compare=5, MTC0 Count=0:
//    - Timer flag sets when Count reaches 5; Cause.IP7=1.
//    - MTC0 Compare=100 clears it.
//  5 SYSCALL and enabled interrupt together: out_data=EXC_VECTOR, ExcCode=8, exc_req=0. Interrupt is masked next cycle by EXL=1.
//  6 MTC0 Cause=32'hFFFF_FFFF, then MFC0 13 -> only IP[1:0] changed. MTC0 to reg 8, or with sel=1 -> no state change.

Source files
------------

// File: rtl/cop0_pkg.sv
// Shared definitions for the MIPS coprocessor-0: op codes, register numbers,
// exception codes and the bit layout of Status/Cause.
package cop0_pkg;

  typedef enum logic [3:0] {
    COP_NOP     = 4'd0,
    COP_SYSCALL = 4'd1,
    COP_BREAK   = 4'd2,
    COP_ERET    = 4'd3
  } cop_op_e;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_BD     = 31;

  function automatic logic [31:0] pack_status(input logic ie, input logic exl,
                                              input logic [7:0] im);
    logic [31:0] r;
    r = '0;
    r[STATUS_IE] = ie;
    r[STATUS_EXL] = exl;
    r[STATUS_IM_LO +: 8] = im;
    return r;
  endfunction

  // Branch-delay slots are never reported, so BD is forced low.
  function automatic logic [31:0] pack_cause(input logic [7:0] ip,
                                             input logic [4:0] exc_code);
    logic [31:0] r;
    r = '0;
    r[CAUSE_IP_LO +: 8] = ip;
    r[CAUSE_EXC_LO +: 5] = exc_code;
    r[CAUSE_BD] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/cop0_timer.sv
// Count/Compare pair with the sticky timer-interrupt flag.
module cop0_timer
  import cop0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count_i,
  input  logic        wr_compare_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_q, timer_d;

  // A Compare of zero is treated as "timer disarmed"; rewriting Compare acks the flag.
  always_comb begin
    count_d   = wr_count_i ? wr_data_i : count_q + 32'd1;
    compare_d = wr_compare_i ? wr_data_i : compare_q;
    timer_d   = timer_q | ((count_q == compare_q) && (compare_q != 32'd0));
    if (wr_compare_i) timer_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      timer_q   <= timer_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign timer_o   = timer_q;

endmodule

// File: rtl/cop0_unit.sv
// MIPS coprocessor-0: system registers, MFC0/MTC0, SYSCALL/BREAK/ERET and
// interrupt entry, plus the redirect address for the PC unit.
module cop0_unit
  import cop0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter logic [31:0] PRID_VALUE = 32'h0001_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  reg_num,
  input  logic [2:0]  reg_sel,
  input  logic [31:0] in_data,
  input  logic [31:0] next_pc,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [3:0]  cop_op,
  input  logic [19:0] code,
  input  logic [5:0]  hard_int,
  output logic [31:0] out_data,
  output logic        exc_req
);

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [7:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] count, compare;
  logic        timer;
  logic        wr_sel0, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic        is_sys, is_brk, is_eret, pending;
  logic [31:0] rd_data;
  logic        unused_code;

  assign unused_code = ^code;

  assign wr_sel0    = reg_wr && (reg_sel == 3'd0);
  assign wr_count   = wr_sel0 && (reg_num == REG_COUNT);
  assign wr_compare = wr_sel0 && (reg_num == REG_COMPARE);
  assign wr_status  = wr_sel0 && (reg_num == REG_STATUS);
  assign wr_cause   = wr_sel0 && (reg_num == REG_CAUSE);
  assign wr_epc     = wr_sel0 && (reg_num == REG_EPC);

  assign is_sys  = (cop_op == COP_SYSCALL);
  assign is_brk  = (cop_op == COP_BREAK);
  assign is_eret = (cop_op == COP_ERET);

  assign pending = ie_q && !exl_q && |(ip_q & im_q);
  assign exc_req = pending && !(is_sys || is_brk || is_eret);

  cop0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .wr_count_i   (wr_count),
    .wr_compare_i (wr_compare),
    .wr_data_i    (in_data),
    .count_o      (count),
    .compare_o    (compare),
    .timer_o      (timer)
  );

  // MTC0 is applied first so exception entry/exit can override EPC, EXL and ExcCode.
  always_comb begin
    ie_d       = ie_q;
    exl_d      = exl_q;
    im_d       = im_q;
    ip_d       = {hard_int | {timer, 5'b0}, ip_q[1:0]};
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (wr_status) begin
      ie_d  = in_data[STATUS_IE];
      exl_d = in_data[STATUS_EXL];
      im_d  = in_data[STATUS_IM_LO +: 8];
    end
    if (wr_cause) ip_d[1:0] = in_data[CAUSE_IP_LO +: 2];
    if (wr_epc) epc_d = in_data;
    if (is_sys || is_brk) begin
      epc_d      = next_pc - 32'd4;
      exc_code_d = is_sys ? EXC_SYS : EXC_BP;
      exl_d      = 1'b1;
    end else if (is_eret) begin
      exl_d = 1'b0;
    end else if (exc_req) begin
      epc_d      = next_pc;
      exc_code_d = EXC_INT;
      exl_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= '0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      im_q       <= im_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (reg_sel == 3'd0) begin
      case (reg_num)
        REG_BADVADDR: rd_data = '0;
        REG_COUNT:    rd_data = count;
        REG_COMPARE:  rd_data = compare;
        REG_STATUS:   rd_data = pack_status(ie_q, exl_q, im_q);
        REG_CAUSE:    rd_data = pack_cause(ip_q, exc_code_q);
        REG_EPC:      rd_data = epc_q;
        REG_PRID:     rd_data = PRID_VALUE;
        default:      rd_data = '0;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    if (is_sys || is_brk)  out_data = EXC_VECTOR;
    else if (is_eret)      out_data = epc_q;
    else if (exc_req)      out_data = EXC_VECTOR;
    else if (reg_rd)       out_data = rd_data;
  end

endmodule

// File: tb/tb_cop0_unit.sv
// Self-checking bench for cop0_unit: directed scenarios followed by random
// traffic, all compared against a word-level model of the CP0 registers.
module tb_cop0_unit;

  localparam logic [31:0] VEC  = 32'h0000_0180;
  localparam logic [31:0] PRID = 32'h0001_8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  regNum = '0;
  logic [2:0]  regSel = '0;
  logic [31:0] inData = '0;
  logic [31:0] nextPc = '0;
  logic        regWr = 1'b0;
  logic        regRd = 1'b0;
  logic [3:0]  copOp = '0;
  logic [19:0] code = '0;
  logic [5:0]  hardInt = '0;
  logic [31:0] outData;
  logic        excReq;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: architectural register words as software would see them.
  logic [31:0] mStatus, mCause, mEpc, mCount, mCompare;
  logic        mTimer;

  cop0_unit dut (
    .clk      (clk),
    .rst      (rst),
    .reg_num  (regNum),
    .reg_sel  (regSel),
    .in_data  (inData),
    .next_pc  (nextPc),
    .reg_wr   (regWr),
    .reg_rd   (regRd),
    .cop_op   (copOp),
    .code     (code),
    .hard_int (hardInt),
    .out_data (outData),
    .exc_req  (excReq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mStatus = '0; mCause = '0; mEpc = '0; mCount = '0; mCompare = '0; mTimer = 1'b0;
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] num, input logic [2:0] sel);
    if (sel != 3'd0) return 32'd0;
    case (num)
      5'd9:    return mCount;
      5'd11:   return mCompare;
      5'd12:   return mStatus;
      5'd13:   return mCause;
      5'd14:   return mEpc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic modelExc();
    logic pend;
    pend = mStatus[0] && !mStatus[1] && ((mCause[15:8] & mStatus[15:8]) != 8'd0);
    return pend && !(copOp == 4'd1 || copOp == 4'd2 || copOp == 4'd3);
  endfunction

  function automatic logic [31:0] modelOut();
    if (copOp == 4'd1 || copOp == 4'd2) return VEC;
    if (copOp == 4'd3) return mEpc;
    if (modelExc()) return VEC;
    if (regRd) return modelRead(regNum, regSel);
    return 32'd0;
  endfunction

  task automatic modelStep();
    logic        exc, wrS, matched;
    logic [31:0] newCount;
    logic        newTimer;
    logic [5:0]  ipHigh;
    exc      = modelExc();
    wrS      = regWr && (regSel == 3'd0);
    matched  = (mCount == mCompare) && (mCompare != 32'd0);
    newCount = (wrS && regNum == 5'd9) ? inData : mCount + 32'd1;
    newTimer = (wrS && regNum == 5'd11) ? 1'b0 : (mTimer | matched);
    ipHigh   = hardInt | {mTimer, 5'b0};
    if (wrS && regNum == 5'd11) mCompare = inData;
    if (wrS && regNum == 5'd12) mStatus = inData & 32'h0000_FF03;
    if (wrS && regNum == 5'd13) mCause = (mCause & ~32'h0000_0300) | (inData & 32'h0000_0300);
    if (wrS && regNum == 5'd14) mEpc = inData;
    mCause[15:10] = ipHigh;
    if (copOp == 4'd1 || copOp == 4'd2) begin
      mEpc = nextPc - 32'd4;
      mCause[6:2] = (copOp == 4'd1) ? 5'd8 : 5'd9;
      mStatus[1] = 1'b1;
    end else if (copOp == 4'd3) begin
      mStatus[1] = 1'b0;
    end else if (exc) begin
      mEpc = nextPc;
      mCause[6:2] = 5'd0;
      mStatus[1] = 1'b1;
    end
    mCount = newCount;
    mTimer = newTimer;
  endtask

  task automatic applyStimulus(input logic [4:0] num, input logic [2:0] sel,
                               input logic wr, input logic rd, input logic [31:0] data,
                               input logic [3:0] op, input logic [31:0] pc,
                               input logic [5:0] hint);
    regNum = num; regSel = sel; regWr = wr; regRd = rd; inData = data;
    copOp = op; nextPc = pc; hardInt = hint; code = 20'($urandom());
    #2;
  endtask

  task automatic checkModel();
    checkOutput("out_data", outData, modelOut());
    checkOutput("exc_req", {31'd0, excReq}, {31'd0, modelExc()});
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic cycle(input logic [4:0] num, input logic [2:0] sel, input logic wr,
                       input logic rd, input logic [31:0] data, input logic [3:0] op,
                       input logic [31:0] pc, input logic [5:0] hint);
    applyStimulus(num, sel, wr, rd, data, op, pc, hint);
    checkModel();
    stepClock();
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    applyStimulus(5'd9, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("reset count", outData, 32'd0);
    checkOutput("reset exc_req", {31'd0, excReq}, 32'd0);
    stepClock();
    applyStimulus(5'd12, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("reset status", outData, 32'd0); stepClock();
    applyStimulus(5'd13, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("reset cause", outData, 32'd0); stepClock();
    applyStimulus(5'd14, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("reset epc", outData, 32'd0); stepClock();
    applyStimulus(5'd15, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("prid", outData, PRID); stepClock();

    // SYSCALL then ERET
    applyStimulus(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 4'd1, 32'h0000_3008, 6'd0);
    checkOutput("syscall vector", outData, VEC); checkModel(); stepClock();
    applyStimulus(5'd14, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("syscall epc", outData, 32'h0000_3004); stepClock();
    applyStimulus(5'd13, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("syscall exccode", {27'd0, outData[6:2]}, 32'd8); stepClock();
    applyStimulus(5'd12, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("syscall exl", {31'd0, outData[1]}, 32'd1); stepClock();
    applyStimulus(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 4'd3, 32'd0, 6'd0);
    checkOutput("eret target", outData, 32'h0000_3004); stepClock();
    applyStimulus(5'd12, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("eret exl", {31'd0, outData[1]}, 32'd0); stepClock();

    // Hardware interrupt on line 0 (IP2)
    cycle(5'd12, 3'd0, 1'b1, 1'b0, 32'h0000_0401, 4'd0, 32'd0, 6'b000001);
    applyStimulus(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 4'd0, 32'h0000_4000, 6'b000001);
    checkOutput("int exc_req", {31'd0, excReq}, 32'd1);
    checkOutput("int vector", outData, VEC); stepClock();
    applyStimulus(5'd13, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'b000001);
    checkOutput("int cause", outData, 32'h0000_0400);
    checkOutput("int masked", {31'd0, excReq}, 32'd0); stepClock();
    applyStimulus(5'd14, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'b000001);
    checkOutput("int epc", outData, 32'h0000_4000); stepClock();
    applyStimulus(5'd12, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'b000001);
    checkOutput("int status", outData, 32'h0000_0403); stepClock();
    cycle(5'd12, 3'd0, 1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 6'd0);

    // Timer
    cycle(5'd11, 3'd0, 1'b1, 1'b0, 32'd5, 4'd0, 32'd0, 6'd0);
    cycle(5'd9, 3'd0, 1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 6'd0);
    for (int i = 0; i < 8; i++) cycle(5'd13, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    applyStimulus(5'd13, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("timer ip7 set", {31'd0, outData[15]}, 32'd1); stepClock();
    cycle(5'd11, 3'd0, 1'b1, 1'b0, 32'd100, 4'd0, 32'd0, 6'd0);
    cycle(5'd13, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    applyStimulus(5'd13, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("timer ip7 clear", {31'd0, outData[15]}, 32'd0); stepClock();

    // SYSCALL beats a pending interrupt
    cycle(5'd12, 3'd0, 1'b1, 1'b0, 32'h0000_0401, 4'd0, 32'd0, 6'b000001);
    applyStimulus(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 4'd1, 32'h0000_5000, 6'b000001);
    checkOutput("sys+int vector", outData, VEC);
    checkOutput("sys+int exc_req", {31'd0, excReq}, 32'd0); stepClock();
    applyStimulus(5'd13, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'b000001);
    checkOutput("sys+int exccode", {27'd0, outData[6:2]}, 32'd8);
    checkOutput("sys+int masked", {31'd0, excReq}, 32'd0); stepClock();
    cycle(5'd12, 3'd0, 1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 6'd0);
    cycle(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 6'd0);

    // Write masks and ignored writes
    cycle(5'd13, 3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'd0, 32'd0, 6'd0);
    applyStimulus(5'd13, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("cause mask", outData, 32'h0000_0320); stepClock();
    cycle(5'd8, 3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'd0, 32'd0, 6'd0);
    cycle(5'd12, 3'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'd0, 32'd0, 6'd0);
    applyStimulus(5'd12, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("status sel1 ignored", outData, 32'd0); stepClock();
    applyStimulus(5'd8, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("badvaddr", outData, 32'd0); stepClock();
    applyStimulus(5'd13, 3'd1, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("sel1 read", outData, 32'd0); stepClock();
    cycle(5'd13, 3'd0, 1'b1, 1'b0, 32'd0, 4'd0, 32'd0, 6'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  num;
      logic [2:0]  sel;
      logic [31:0] data;
      logic [3:0]  op;
      logic [5:0]  hint;
      case ($urandom_range(0, 7))
        0: num = 5'd9;  1: num = 5'd11; 2: num = 5'd12; 3: num = 5'd13;
        4: num = 5'd14; 5: num = 5'd15; 6: num = 5'd8;
        default: num = 5'($urandom());
      endcase
      sel  = ($urandom_range(0, 9) == 0) ? 3'($urandom()) : 3'd0;
      data = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
      op   = ($urandom_range(0, 9) < 7) ? 4'd0 : 4'($urandom_range(1, 3));
      hint = ($urandom_range(0, 4) == 0) ? 6'($urandom()) : 6'd0;
      cycle(num, sel, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), data, op,
            $urandom() & 32'hFFFF_FFFC, hint);
    end

    // Asynchronous reset mid-run
    cycle(5'd14, 3'd0, 1'b1, 1'b0, 32'hDEAD_BEE0, 4'd0, 32'd0, 6'd0);
    applyStimulus(5'd14, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async reset epc", outData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stepClock();
    applyStimulus(5'd9, 3'd0, 1'b0, 1'b1, 32'd0, 4'd0, 32'd0, 6'd0);
    checkOutput("count after reset", outData, 32'd1);
    checkModel();
    stepClock();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
